btn_press_repeat: RTL
=====================

// Module: btn_press_repeat
// PURPOSE
//  Source side of the button-event path. Conditions a raw board key into clean events for
//  edge detectors, toggles and parameter steppers in the signal generator.
//  - Synchronises and debounces the key.
//  - Emits a one-cycle press pulse, then auto-repeat pulses while the key is held, then a
//    release pulse.
//  Sits between the KEY pins and the per-button edge/toggle logic.
// PARAMETERS
//  DEBOUNCE_CYC      1_000_000   consecutive stable clocks required to accept a level change (>=1)
//  REPEAT_DELAY_CYC  25_000_000  clocks from press_o to the first repeat_o (>=1)
//  REPEAT_RATE_CYC   5_000_000   clocks between subsequent repeat_o pulses (>=1)
//  ACTIVE_LOW        1           1: btn_i==0 means pressed; 0: btn_i==1 means pressed
// PORTS
//  clk_i        in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  btn_i        in   1  raw key, asynchronous to clk_i, may bounce
//  btn_level_o  out  1  debounced level, 1 = pressed (polarity normalised)
//  press_o      out  1  one-cycle pulse on accepted press
//  repeat_o     out  1  one-cycle pulse per auto-repeat tick
//  release_o    out  1  one-cycle pulse on accepted release
//  long_o       out  1  long-press level (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs are 0. Both synchroniser FFs load the released value. Counters are 0.
//    FSM is IDLE. Reset acts immediately, including mid-operation.
//  - Sync: 2-FF synchroniser, then polarity normalisation. Result: sync_p (1 = pressed).
//  - Debounce:
//    - db_cnt increments each clock while sync_p != btn_level_o.
//    - db_cnt clears to 0 on any cycle with sync_p == btn_level_o.
//    - When db_cnt == DEBOUNCE_CYC-1 and sync_p still differs, btn_level_o <= sync_p and
//      db_cnt <= 0.
//    - Latency from the first btn_i sample of the new level to the btn_level_o change is
//      2 + DEBOUNCE_CYC clocks.
//    - Glitches shorter than DEBOUNCE_CYC synced cycles produce no event.
//  - FSM states: IDLE, HELD_WAIT, REPEAT. One shared timer, width
//    $clog2(max(REPEAT_DELAY_CYC, REPEAT_RATE_CYC) + 1).
//    - IDLE: on accepted press, press_o=1 for the same cycle btn_level_o rises. Timer <= 0.
//      Next state HELD_WAIT.
//    - HELD_WAIT: timer increments. At timer == REPEAT_DELAY_CYC-1: repeat_o=1, timer <= 0,
//      next state REPEAT.
//    - REPEAT: timer increments. At timer == REPEAT_RATE_CYC-1: repeat_o=1, timer <= 0.
//    - Any state on accepted release: release_o=1 in the cycle btn_level_o falls. Timer <= 0.
//      Next state IDLE. Release has priority over a repeat tick due in the same cycle, so
//      repeat_o=0 in that cycle.
//  - press_o, repeat_o and release_o are registered and mutually exclusive. Each is never high
//    for more than 1 cycle.
//  - The timer never wraps. It is cleared at every terminal count and on every state change.
//  - Key held through reset: after rst_n deasserts, a fresh press_o fires 2+DEBOUNCE_CYC
//    clocks later.
// CONFIGURATION
//  Macro BTN_LONG_PRESS_EN:
//  - Defined: long_o <= 1 in the cycle of the first repeat_o (HELD_WAIT -> REPEAT).
//    It holds 1 until the release_o cycle, where it returns to 0.
//  - Undefined: long_o is constant 0 and no extra state is kept. All other behaviour is
//    identical in both builds.
// TESTING
//  Parameter overrides for all scenarios: DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20,
//  REPEAT_RATE_CYC=5, ACTIVE_LOW=1.
//  1. rst_n=0 for 3 clocks with btn_i=1 -> all outputs 0; no pulse in 20 clocks after
//     deassert.
//  2. btn_i low for 3 clocks, then high -> btn_level_o stays 0; no press_o, repeat_o or
//     release_o.
//  3. btn_i falls at cycle 0 and is held -> btn_level_o=1 and press_o=1 exactly at cycle 6;
//     repeat_o at cycles 26, 31, 36, 41.
//  4. Press, then release 10 clocks after press_o -> no repeat_o; release_o one pulse 6 clocks
//     after btn_i rises; FSM IDLE.
//  5. Release timed so the accepted release coincides with a due repeat tick -> release_o=1,
//     repeat_o=0 that cycle.
//  6. rst_n pulsed during REPEAT with key held -> outputs 0 at once; press_o 6 clocks after
//     deassert. BTN_LONG_PRESS_EN build: long_o=1 from cycle 26 of scenario 3 until the
//     release_o cycle.

Source files
------------

// File: rtl/btn_press_repeat.sv
// -----------------------------------------------------------------------------
// btn_press_repeat
//
// Conditions one raw board key into clean, single-cycle events for the
// per-button edge/toggle/stepper logic of the signal generator.
//
//   raw key -> 2-FF synchroniser -> polarity normalise (sync_p, 1 = pressed)
//           -> debounce counter   -> btn_level_o
//           -> event FSM          -> press_o / repeat_o / release_o / long_o
//
// Event timeline while a key is held:
//   press_o on the cycle btn_level_o rises,
//   first repeat_o REPEAT_DELAY_CYC clocks after press_o,
//   further repeat_o every REPEAT_RATE_CYC clocks,
//   release_o on the cycle btn_level_o falls. A release always wins over a
//   repeat tick falling due in the same cycle.
//
// Parameters:
//   DEBOUNCE_CYC      consecutive stable synced clocks to accept a change (>=1)
//   REPEAT_DELAY_CYC  clocks from press_o to the first repeat_o          (>=1)
//   REPEAT_RATE_CYC   clocks between subsequent repeat_o pulses          (>=1)
//   ACTIVE_LOW        1: btn_i==0 means pressed, 0: btn_i==1 means pressed
//
// Ports:
//   clk_i        in   system clock
//   rst_n        in   asynchronous active-low reset
//   btn_i        in   raw key, asynchronous to clk_i, may bounce
//   btn_level_o  out  debounced level, 1 = pressed
//   press_o      out  one-cycle pulse on accepted press
//   repeat_o     out  one-cycle pulse per auto-repeat tick
//   release_o    out  one-cycle pulse on accepted release
//   long_o       out  long-press level
//
// Build option:
//   BTN_LONG_PRESS_EN  defined: long_o rises with the first repeat_o and falls
//                      with release_o. Undefined: long_o is tied to 0 and no
//                      extra flop is built.
// -----------------------------------------------------------------------------
module btn_press_repeat #(
    parameter int DEBOUNCE_CYC     = 1_000_000,
    parameter int REPEAT_DELAY_CYC = 25_000_000,
    parameter int REPEAT_RATE_CYC  = 5_000_000,
    parameter bit ACTIVE_LOW       = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic btn_i,
    output logic btn_level_o,
    output logic press_o,
    output logic repeat_o,
    output logic release_o,
    output logic long_o
);

    // -------------------------------------------------------------------------
    // Derived sizes and terminal counts
    // -------------------------------------------------------------------------
    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMR_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                             REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE_CYC - 1);

    // Raw pin value meaning "released"; the synchroniser resets to it so a key
    // held through reset is seen as a fresh press afterwards.
    localparam logic RELEASED_RAW = ACTIVE_LOW;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HELD_WAIT = 2'd1,
        ST_REPEAT    = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic              sync1_q,   sync1_d;
    logic              sync2_q,   sync2_d;
    logic [DB_W-1:0]   db_cnt_q,  db_cnt_d;
    logic              level_q,   level_d;
    state_e            state_q,   state_d;
    logic [TMR_W-1:0]  timer_q,   timer_d;
    logic              press_q,   press_d;
    logic              repeat_q,  repeat_d;
    logic              release_q, release_d;

    logic              sync_p;
    logic              accept_press;
    logic              accept_release;

    // -------------------------------------------------------------------------
    // Synchroniser and polarity normalisation
    // -------------------------------------------------------------------------
    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
    end

    assign sync_p = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // -------------------------------------------------------------------------
    // Debounce: the new level must be seen for DEBOUNCE_CYC consecutive synced
    // cycles; any cycle agreeing with the current level restarts the count.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        db_cnt_d       = '0;
        level_d        = level_q;
        accept_press   = 1'b0;
        accept_release = 1'b0;

        if (sync_p != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d        = sync_p;
                accept_press   = sync_p;
                accept_release = ~sync_p;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Event FSM with one shared timer. The event pulses are computed from the
    // same acceptance strobes that move btn_level_o, so press_o/release_o land
    // in exactly the cycle the level changes.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        press_d   = 1'b0;
        repeat_d  = 1'b0;
        release_d = 1'b0;

        if (accept_release) begin
            // Release outranks a repeat tick due in the same cycle.
            release_d = 1'b1;
            timer_d   = '0;
            state_d   = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    timer_d = '0;
                    if (accept_press) begin
                        press_d = 1'b1;
                        state_d = ST_HELD_WAIT;
                    end
                end

                ST_HELD_WAIT: begin
                    if (timer_q == DELAY_LAST) begin
                        repeat_d = 1'b1;
                        timer_d  = '0;
                        state_d  = ST_REPEAT;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                ST_REPEAT: begin
                    if (timer_q == RATE_LAST) begin
                        repeat_d = 1'b1;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                default: begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: the reset is asynchronous (in the sensitivity list) so outputs clear
    // the moment rst_n falls, even mid-operation, without waiting for a clock.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= RELEASED_RAW;
            sync2_q   <= RELEASED_RAW;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            press_q   <= 1'b0;
            repeat_q  <= 1'b0;
            release_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            press_q   <= press_d;
            repeat_q  <= repeat_d;
            release_q <= release_d;
        end
    end

    assign btn_level_o = level_q;
    assign press_o     = press_q;
    assign repeat_o    = repeat_q;
    assign release_o   = release_q;

    // -------------------------------------------------------------------------
    // Optional long-press level: high exactly while the FSM sits in REPEAT,
    // i.e. from the first repeat_o cycle up to (not including) release_o.
    // -------------------------------------------------------------------------
`ifdef BTN_LONG_PRESS_EN
    logic long_q, long_d;

    always_comb begin
        long_d = (state_d == ST_REPEAT);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            long_q <= 1'b0;
        end else begin
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule
